// File: rtl/rk4_pkg.sv
// Shared types and constants for the result UART path.
// Q16.16 word width, UART framing and transmitter state encodings.
package rk4_pkg;

  localparam int Q_WIDTH = 32;
  localparam int UART_BITS_PER_BYTE = 10;
  localparam int DATA_BITS = UART_BITS_PER_BYTE - 2;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_START_BIT,
    ST_DATA,
    ST_STOP
  } tx_state_e;

endpackage

// File: rtl/result_uart_tx_baud_tick.sv
// Bit-period counter for the result UART.
// Emits a one-cycle tick on the last cycle of each bit period.
module baud_tick #(
  parameter int CLKS_PER_BIT = 868
) (
  input  logic clk,
  input  logic clr,
  input  logic restart,
  input  logic en,
  output logic tick
);

  localparam int CW =
    (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

  logic [CW-1:0] cnt_q = '0;
  logic [CW-1:0] cnt_d;

  assign tick = en && (cnt_q == LAST);

  always_comb begin
    cnt_d = cnt_q;
    if (restart) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = tick ? '0 : cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/result_uart_tx.sv
// Serialises one Q16.16 result word over UART, 8N1.
// Bytes go MSB first, bits within a byte LSB first.
module result_uart_tx
  import rk4_pkg::*;
#(
  parameter int CLKS_PER_BIT = 868,
  parameter int NUM_BYTES    = 4
) (
  input  logic               CLK,
  input  logic               CLR,
  input  logic [Q_WIDTH-1:0] data_in,
  input  logic               START,
  output logic               TX,
  output logic               BUSY,
  output logic               DONE
);

  localparam int BW =
    (NUM_BYTES > 1) ? $clog2(NUM_BYTES) : 1;
  localparam logic [BW-1:0] BYTE_LAST = BW'(NUM_BYTES - 1);
  localparam logic [2:0] BIT_LAST = 3'(DATA_BITS - 1);

  tx_state_e          state_q = ST_IDLE;
  logic [Q_WIDTH-1:0] shift_q = '0;
  logic [2:0]         bit_q   = '0;
  logic [BW-1:0]      byte_q  = '0;
  logic               tx_q    = 1'b1;
  logic               busy_q  = 1'b0;
  logic               done_q  = 1'b0;

  tx_state_e          state_d;
  logic [Q_WIDTH-1:0] shift_d;
  logic [2:0]         bit_d;
  logic [BW-1:0]      byte_d;
  logic               tx_d;
  logic               busy_d;
  logic               done_d;

  logic       start_frame;
  logic       tick;
  logic [7:0] cur;
  logic [2:0] nxt_bit;

  baud_tick #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud (
    .clk    (CLK),
    .clr    (CLR),
    .restart(start_frame),
    .en     (busy_q),
    .tick   (tick)
  );

  assign cur     = shift_q[Q_WIDTH-1 -: 8];
  assign nxt_bit = bit_q + 3'd1;

  always_comb begin
    state_d     = state_q;
    shift_d     = shift_q;
    bit_d       = bit_q;
    byte_d      = byte_q;
    tx_d        = tx_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    start_frame = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (START) begin
          start_frame = 1'b1;
          shift_d     = data_in;
          state_d     = ST_START_BIT;
          tx_d        = 1'b0;
          busy_d      = 1'b1;
          bit_d       = '0;
          byte_d      = '0;
        end
      end
      ST_START_BIT: begin
        if (tick) begin
          state_d = ST_DATA;
          tx_d    = cur[0];
        end
      end
      ST_DATA: begin
        if (tick) begin
          if (bit_q == BIT_LAST) begin
            state_d = ST_STOP;
            tx_d    = 1'b1;
            bit_d   = '0;
          end else begin
            bit_d = nxt_bit;
            tx_d  = cur[nxt_bit];
          end
        end
      end
      ST_STOP: begin
        if (tick) begin
          if (byte_q == BYTE_LAST) begin
            state_d = ST_IDLE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            byte_d  = '0;
            shift_d = '0;
          end else begin
            // next byte follows the stop bit with no idle gap
            byte_d  = byte_q + 1'b1;
            shift_d = shift_q << 8;
            state_d = ST_START_BIT;
            tx_d    = 1'b0;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (CLR) begin
      state_q <= ST_IDLE;
      shift_q <= '0;
      bit_q   <= '0;
      byte_q  <= '0;
      tx_q    <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      bit_q   <= bit_d;
      byte_q  <= byte_d;
      tx_q    <= tx_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign TX   = tx_q;
  assign BUSY = busy_q;
  assign DONE = done_q;

endmodule

// File: tb/tb_result_uart_tx.sv
// Self-checking bench for result_uart_tx.
// Directed frame vectors plus abort, restart and back-to-back cases.
module tb_result_uart_tx;

  localparam int CPB   = 4;
  localparam int NB    = 4;
  localparam int FRAME = NB * 10 * CPB;

  typedef struct {
    logic [31:0] data;
    logic [7:0]  b0;
    logic [7:0]  b1;
    logic [7:0]  b2;
    logic [7:0]  b3;
  } vec_t;

  logic        clk = 1'b0;
  logic        clr = 1'b1;
  logic        start = 1'b0;
  logic [31:0] data_in = '0;
  logic        tx;
  logic        busy;
  logic        done;

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  result_uart_tx #(
    .CLKS_PER_BIT(CPB),
    .NUM_BYTES   (NB)
  ) dut (
    .CLK    (clk),
    .CLR    (clr),
    .data_in(data_in),
    .START  (start),
    .TX     (tx),
    .BUSY   (busy),
    .DONE   (done)
  );

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act === exp) begin
      passed++;
    end else begin
      $display("FAIL %s: got %h, expected %h",
               name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Called in the first cycle after the capturing edge.
  task automatic check_frame(input string name,
                             input logic [7:0] b0,
                             input logic [7:0] b1,
                             input logic [7:0] b2,
                             input logic [7:0] b3,
                             input int poke_k,
                             input bit hold);
    logic [7:0] cur;
    logic       expb;
    int         j;
    int         tx_err = 0;
    int         busy_err = 0;
    int         done_err = 0;
    for (int k = 0; k < FRAME; k++) begin
      case (k / (10 * CPB))
        0:       cur = b0;
        1:       cur = b1;
        2:       cur = b2;
        default: cur = b3;
      endcase
      j = (k / CPB) % 10;
      if (j == 0)      expb = 1'b0;
      else if (j == 9) expb = 1'b1;
      else             expb = cur[j-1];
      if (tx !== expb) tx_err++;
      if (busy !== 1'b1) busy_err++;
      if (done !== 1'b0) done_err++;
      if (k == poke_k) begin
        start   = 1'b1;
        data_in = 32'h1234_5678;
      end else if (poke_k >= 0 && k == poke_k + 1) begin
        start = 1'b0;
      end
      step();
    end
    chk({name, " tx bits"}, tx_err, 0);
    chk({name, " busy span"}, busy_err, 0);
    chk({name, " early done"}, done_err, 0);
    chk({name, " done pulse"}, {31'b0, done}, 1);
    chk({name, " busy drop"}, {31'b0, busy}, 0);
    chk({name, " tx idle"}, {31'b0, tx}, 1);
    if (!hold) begin
      step();
      chk({name, " done width"}, {31'b0, done}, 0);
      chk({name, " stays idle"}, {31'b0, busy}, 0);
    end
  endtask

  vec_t vecs[4];

  initial begin
    int dcnt;
    int lcnt;

    vecs[0] = '{32'h0001_8000, 8'h00, 8'h01, 8'h80, 8'h00};
    vecs[1] = '{32'hFFFF_0000, 8'hFF, 8'hFF, 8'h00, 8'h00};
    vecs[2] = '{32'h0000_0000, 8'h00, 8'h00, 8'h00, 8'h00};
    vecs[3] = '{32'h8000_0001, 8'h80, 8'h00, 8'h00, 8'h01};

    step();
    step();
    chk("reset tx", {31'b0, tx}, 1);
    chk("reset busy", {31'b0, busy}, 0);
    chk("reset done", {31'b0, done}, 0);
    clr = 1'b0;
    step();

    for (int i = 0; i < 4; i++) begin
      data_in = vecs[i].data;
      start   = 1'b1;
      chk($sformatf("vec%0d pre tx", i), {31'b0, tx}, 1);
      step();
      start   = 1'b0;
      data_in = ~vecs[i].data;
      check_frame($sformatf("vec%0d", i),
                  vecs[i].b0, vecs[i].b1,
                  vecs[i].b2, vecs[i].b3, -1, 1'b0);
    end

    data_in = 32'h0001_8000;
    start   = 1'b1;
    step();
    start = 1'b0;
    check_frame("restart", 8'h00, 8'h01, 8'h80, 8'h00,
                20, 1'b0);

    data_in = 32'hFFFF_0000;
    start   = 1'b1;
    step();
    start = 1'b0;
    repeat (50) step();
    clr = 1'b1;
    step();
    clr = 1'b0;
    chk("abort tx", {31'b0, tx}, 1);
    chk("abort busy", {31'b0, busy}, 0);
    chk("abort done", {31'b0, done}, 0);
    dcnt = 0;
    lcnt = 0;
    for (int k = 0; k < FRAME + 10; k++) begin
      if (done !== 1'b0) dcnt++;
      if (tx !== 1'b1) lcnt++;
      step();
    end
    chk("abort no done", dcnt, 0);
    chk("abort line idle", lcnt, 0);
    data_in = 32'h0001_8000;
    start   = 1'b1;
    step();
    start = 1'b0;
    check_frame("post abort", 8'h00, 8'h01, 8'h80, 8'h00,
                -1, 1'b0);

    data_in = 32'hA5A5_A5A5;
    start   = 1'b1;
    step();
    check_frame("held1", 8'hA5, 8'hA5, 8'hA5, 8'hA5,
                -1, 1'b1);
    step();
    start = 1'b0;
    check_frame("held2", 8'hA5, 8'hA5, 8'hA5, 8'hA5,
                -1, 1'b0);

    clr     = 1'b1;
    start   = 1'b1;
    data_in = 32'h0001_8000;
    step();
    clr   = 1'b0;
    start = 1'b0;
    chk("clr+start busy", {31'b0, busy}, 0);
    chk("clr+start tx", {31'b0, tx}, 1);
    dcnt = 0;
    lcnt = 0;
    for (int k = 0; k < 20; k++) begin
      if (busy !== 1'b0) dcnt++;
      if (tx !== 1'b1) lcnt++;
      step();
    end
    chk("clr+start no frame", dcnt, 0);
    chk("clr+start line", lcnt, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
